// File: rtl/axi_lite_pkg.sv
// AXI4-Lite demux shared definitions: response codes and FSM state encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_ISSUE = 2'd1,
        W_WAITB = 2'd2,
        W_RESP  = 2'd3
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_ISSUE = 2'd1,
        R_WAITR = 2'd2,
        R_RESP  = 2'd3
    } r_state_t;

endpackage

// File: rtl/axi_lite_addr_decoder.sv
// Address decoder: maps an address onto the base/mask table, lowest index wins.
// Latency: purely combinational.
// Backpressure: none; stateless.
//
// Ports:
//   addr_i  address to decode
//   hit_o   one-hot select of the winning slave (all zero on miss)
//   idx_o   encoded index of the winning slave (0 on miss)
//   miss_o  no slave matched
module axi_lite_addr_decoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_SLAVES = 2,
    parameter int IDX_WIDTH  = 1,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS = {8'h10, 8'h00},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] ADDR_MASKS = {8'hF0, 8'hF0}
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [NUM_SLAVES-1:0] hit_o,
    output logic [IDX_WIDTH-1:0]  idx_o,
    output logic                  miss_o
);

    always_comb begin
        hit_o  = '0;
        idx_o  = '0;
        miss_o = 1'b1;
        // miss_o doubles as "nothing matched yet", giving lowest-index priority.
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (miss_o &&
                ((addr_i & ADDR_MASKS[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                 BASE_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit_o[i] = 1'b1;
                idx_o    = IDX_WIDTH'(i);
                miss_o   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_lite_demux.sv
// AXI4-Lite 1-to-N router; unmapped addresses answered locally with DECERR.
// Latency: request forwarded one edge after capture; response one edge after downstream handshake.
// Backpressure: one outstanding read and one outstanding write; upstream readies low while busy.
//
// Ports:
//   axi_aclk / axi_areset     clock, async active-high reset
//   s_axi_aw*/w*/b*/ar*/r*    upstream slave port
//   m_axi_aw*/w*/b*/ar*/r*    downstream master ports, slave i in slice i of each flattened bus
module axi_lite_demux
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 2,
    parameter int NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS = {8'h10, 8'h00},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] ADDR_MASKS = {8'hF0, 8'hF0}
) (
    input  logic                               axi_aclk,
    input  logic                               axi_areset,
    // upstream write
    input  logic [ADDR_WIDTH-1:0]              s_axi_awaddr,
    input  logic                               s_axi_awvalid,
    output logic                               s_axi_awready,
    input  logic [DATA_WIDTH-1:0]              s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]            s_axi_wstrb,
    input  logic                               s_axi_wvalid,
    output logic                               s_axi_wready,
    output logic [RESP_WIDTH-1:0]              s_axi_bresp,
    output logic                               s_axi_bvalid,
    input  logic                               s_axi_bready,
    // upstream read
    input  logic [ADDR_WIDTH-1:0]              s_axi_araddr,
    input  logic                               s_axi_arvalid,
    output logic                               s_axi_arready,
    output logic [DATA_WIDTH-1:0]              s_axi_rdata,
    output logic [RESP_WIDTH-1:0]              s_axi_rresp,
    output logic                               s_axi_rvalid,
    input  logic                               s_axi_rready,
    // downstream write
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [NUM_SLAVES-1:0]              m_axi_awvalid,
    input  logic [NUM_SLAVES-1:0]              m_axi_awready,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [NUM_SLAVES*DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic [NUM_SLAVES-1:0]              m_axi_wvalid,
    input  logic [NUM_SLAVES-1:0]              m_axi_wready,
    input  logic [NUM_SLAVES*RESP_WIDTH-1:0]   m_axi_bresp,
    input  logic [NUM_SLAVES-1:0]              m_axi_bvalid,
    output logic [NUM_SLAVES-1:0]              m_axi_bready,
    // downstream read
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [NUM_SLAVES-1:0]              m_axi_arvalid,
    input  logic [NUM_SLAVES-1:0]              m_axi_arready,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [NUM_SLAVES*RESP_WIDTH-1:0]   m_axi_rresp,
    input  logic [NUM_SLAVES-1:0]              m_axi_rvalid,
    output logic [NUM_SLAVES-1:0]              m_axi_rready
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    // Goes high on the first edge out of reset so no ready is raised while in reset.
    logic live_q;

    // ---------------- write path ----------------
    w_state_t                w_state_q, w_state_d;
    logic                    aw_got_q, w_got_q, awdone_q, wdone_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic [IDX_W-1:0]        widx_q;
    logic [NUM_SLAVES-1:0]   wsel_q;
    logic [RESP_WIDTH-1:0]   bresp_q;

    logic                    aw_hs, w_hs, aw_have, w_have, aw_dn_hs, w_dn_hs;
    logic [ADDR_WIDTH-1:0]   awaddr_nxt;
    logic [NUM_SLAVES-1:0]   w_hit;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_miss;

    assign aw_hs   = s_axi_awvalid && s_axi_awready;
    assign w_hs    = s_axi_wvalid && s_axi_wready;
    assign aw_have = aw_got_q || aw_hs;
    assign w_have  = w_got_q || w_hs;
    // Decode the address that will be held after this edge, so a same-edge AW capture is routed.
    assign awaddr_nxt = aw_hs ? s_axi_awaddr : awaddr_q;
    assign aw_dn_hs = (w_state_q == W_ISSUE) && !awdone_q && m_axi_awready[widx_q];
    assign w_dn_hs  = (w_state_q == W_ISSUE) && !wdone_q && m_axi_wready[widx_q];

    axi_lite_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_WIDTH  (IDX_W),
        .BASE_ADDRS (BASE_ADDRS),
        .ADDR_MASKS (ADDR_MASKS)
    ) u_wdec (
        .addr_i (awaddr_nxt),
        .hit_o  (w_hit),
        .idx_o  (w_idx),
        .miss_o (w_miss)
    );

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            live_q    <= 1'b0;
            w_state_q <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awdone_q  <= 1'b0;
            wdone_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            widx_q    <= '0;
            wsel_q    <= '0;
            bresp_q   <= '0;
        end else begin
            live_q    <= 1'b1;
            w_state_q <= w_state_d;
            if (aw_hs) begin
                awaddr_q <= s_axi_awaddr;
                aw_got_q <= 1'b1;
            end
            if (w_hs) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
                w_got_q <= 1'b1;
            end
            if (aw_dn_hs) awdone_q <= 1'b1;
            if (w_dn_hs)  wdone_q  <= 1'b1;
            if (w_state_q == W_WAITB && m_axi_bvalid[widx_q])
                bresp_q <= m_axi_bresp[widx_q*RESP_WIDTH +: RESP_WIDTH];
            // Leaving idle: latch the route and rearm the per-beat flags.
            if (w_state_q == W_IDLE && aw_have && w_have) begin
                aw_got_q <= 1'b0;
                w_got_q  <= 1'b0;
                awdone_q <= 1'b0;
                wdone_q  <= 1'b0;
                widx_q   <= w_idx;
                wsel_q   <= w_hit;
                if (w_miss) bresp_q <= RESP_WIDTH'(RESP_DECERR);
            end
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_have && w_have) w_state_d = w_miss ? W_RESP : W_ISSUE;
            W_ISSUE: if ((awdone_q || aw_dn_hs) && (wdone_q || w_dn_hs)) w_state_d = W_WAITB;
            W_WAITB: if (m_axi_bvalid[widx_q]) w_state_d = W_RESP;
            W_RESP:  if (s_axi_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = live_q && (w_state_q == W_IDLE) && !aw_got_q;
        s_axi_wready  = live_q && (w_state_q == W_IDLE) && !w_got_q;
        s_axi_bvalid  = (w_state_q == W_RESP);
        s_axi_bresp   = bresp_q;
        m_axi_awvalid = wsel_q & {NUM_SLAVES{(w_state_q == W_ISSUE) && !awdone_q}};
        m_axi_wvalid  = wsel_q & {NUM_SLAVES{(w_state_q == W_ISSUE) && !wdone_q}};
        m_axi_bready  = wsel_q & {NUM_SLAVES{w_state_q == W_WAITB}};
        m_axi_awaddr  = {NUM_SLAVES{awaddr_q}};
        m_axi_wdata   = {NUM_SLAVES{wdata_q}};
        m_axi_wstrb   = {NUM_SLAVES{wstrb_q}};
    end

    // ---------------- read path ----------------
    r_state_t              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [IDX_W-1:0]      ridx_q;
    logic [NUM_SLAVES-1:0] rsel_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [RESP_WIDTH-1:0] rresp_q;

    logic                  ar_hs;
    logic [NUM_SLAVES-1:0] r_hit;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_miss;

    assign ar_hs = s_axi_arvalid && s_axi_arready;

    axi_lite_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_WIDTH  (IDX_W),
        .BASE_ADDRS (BASE_ADDRS),
        .ADDR_MASKS (ADDR_MASKS)
    ) u_rdec (
        .addr_i (s_axi_araddr),
        .hit_o  (r_hit),
        .idx_o  (r_idx),
        .miss_o (r_miss)
    );

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_state_q <= R_IDLE;
            araddr_q  <= '0;
            ridx_q    <= '0;
            rsel_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                araddr_q <= s_axi_araddr;
                ridx_q   <= r_idx;
                rsel_q   <= r_hit;
                if (r_miss) begin
                    rdata_q <= '0;
                    rresp_q <= RESP_WIDTH'(RESP_DECERR);
                end
            end
            if (r_state_q == R_WAITR && m_axi_rvalid[ridx_q]) begin
                rdata_q <= m_axi_rdata[ridx_q*DATA_WIDTH +: DATA_WIDTH];
                rresp_q <= m_axi_rresp[ridx_q*RESP_WIDTH +: RESP_WIDTH];
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = r_miss ? R_RESP : R_ISSUE;
            R_ISSUE: if (m_axi_arready[ridx_q]) r_state_d = R_WAITR;
            R_WAITR: if (m_axi_rvalid[ridx_q]) r_state_d = R_RESP;
            R_RESP:  if (s_axi_rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = live_q && (r_state_q == R_IDLE);
        s_axi_rvalid  = (r_state_q == R_RESP);
        s_axi_rdata   = rdata_q;
        s_axi_rresp   = rresp_q;
        m_axi_arvalid = rsel_q & {NUM_SLAVES{r_state_q == R_ISSUE}};
        m_axi_rready  = rsel_q & {NUM_SLAVES{r_state_q == R_WAITR}};
        m_axi_araddr  = {NUM_SLAVES{araddr_q}};
    end

endmodule

// File: tb/tb_axi_lite_demux.sv
// Bench for axi_lite_demux: directed scenarios with a scoreboard of expected
// downstream requests and upstream responses, checked as handshakes happen.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_axi_lite_demux;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RW = 2;
    localparam int NS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0]      s_axi_awaddr = '0;
    logic               s_axi_awvalid = 1'b0, s_axi_awready;
    logic [DW-1:0]      s_axi_wdata = '0;
    logic [DW/8-1:0]    s_axi_wstrb = '0;
    logic               s_axi_wvalid = 1'b0, s_axi_wready;
    logic [RW-1:0]      s_axi_bresp;
    logic               s_axi_bvalid, s_axi_bready = 1'b0;
    logic [AW-1:0]      s_axi_araddr = '0;
    logic               s_axi_arvalid = 1'b0, s_axi_arready;
    logic [DW-1:0]      s_axi_rdata;
    logic [RW-1:0]      s_axi_rresp;
    logic               s_axi_rvalid, s_axi_rready = 1'b0;

    logic [NS*AW-1:0]   m_axi_awaddr;
    logic [NS-1:0]      m_axi_awvalid, m_axi_awready = '0;
    logic [NS*DW-1:0]   m_axi_wdata;
    logic [NS*DW/8-1:0] m_axi_wstrb;
    logic [NS-1:0]      m_axi_wvalid, m_axi_wready = '0;
    logic [NS*RW-1:0]   m_axi_bresp = '0;
    logic [NS-1:0]      m_axi_bvalid = '0, m_axi_bready;
    logic [NS*AW-1:0]   m_axi_araddr;
    logic [NS-1:0]      m_axi_arvalid, m_axi_arready = '0;
    logic [NS*DW-1:0]   m_axi_rdata = '0;
    logic [NS*RW-1:0]   m_axi_rresp = '0;
    logic [NS-1:0]      m_axi_rvalid = '0, m_axi_rready;

    axi_lite_demux dut (
        .axi_aclk      (clk),
        .axi_areset    (rst),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct { int s; logic [AW-1:0] addr; } a_exp_t;
    typedef struct { int s; logic [DW-1:0] data; logic [DW/8-1:0] strb; } w_exp_t;
    typedef struct { logic [RW-1:0] resp; logic [DW-1:0] data; } r_exp_t;

    a_exp_t       exp_aw[$];
    a_exp_t       exp_ar[$];
    w_exp_t       exp_w[$];
    logic [RW-1:0] exp_b[$];
    r_exp_t       exp_r[$];

    // Scoreboard: at the falling edge, any valid&ready pair completes at the next rising edge.
    always @(negedge clk) begin
        a_exp_t ea;
        w_exp_t ew;
        r_exp_t er;
        logic [RW-1:0] eb;
        if (!rst) begin
            if (m_axi_awvalid != '0 && exp_aw.size() == 0) begin
                tests_run++; tests_failed++;
                $display("FAIL spurious_awvalid: m_awvalid=%b with no write expected", m_axi_awvalid);
            end
            if (m_axi_arvalid != '0 && exp_ar.size() == 0) begin
                tests_run++; tests_failed++;
                $display("FAIL spurious_arvalid: m_arvalid=%b with no read expected", m_axi_arvalid);
            end
            for (int s = 0; s < NS; s++) begin
                if (m_axi_awvalid[s] && m_axi_awready[s] && exp_aw.size() != 0) begin
                    ea = exp_aw.pop_front();
                    tests_run++;
                    if (s !== ea.s || m_axi_awaddr[s*AW +: AW] !== ea.addr) begin
                        tests_failed++;
                        $display("FAIL sb_aw: got slave %0d addr %h, want slave %0d addr %h",
                                 s, m_axi_awaddr[s*AW +: AW], ea.s, ea.addr);
                    end
                end
                if (m_axi_wvalid[s] && m_axi_wready[s]) begin
                    tests_run++;
                    if (exp_w.size() == 0) begin
                        tests_failed++;
                        $display("FAIL sb_w: unexpected W on slave %0d", s);
                    end else begin
                        ew = exp_w.pop_front();
                        if (s !== ew.s || m_axi_wdata[s*DW +: DW] !== ew.data ||
                            m_axi_wstrb[s*DW/8 +: DW/8] !== ew.strb) begin
                            tests_failed++;
                            $display("FAIL sb_w: got slave %0d data %h strb %h, want slave %0d data %h strb %h",
                                     s, m_axi_wdata[s*DW +: DW], m_axi_wstrb[s*DW/8 +: DW/8],
                                     ew.s, ew.data, ew.strb);
                        end
                    end
                end
                if (m_axi_arvalid[s] && m_axi_arready[s] && exp_ar.size() != 0) begin
                    ea = exp_ar.pop_front();
                    tests_run++;
                    if (s !== ea.s || m_axi_araddr[s*AW +: AW] !== ea.addr) begin
                        tests_failed++;
                        $display("FAIL sb_ar: got slave %0d addr %h, want slave %0d addr %h",
                                 s, m_axi_araddr[s*AW +: AW], ea.s, ea.addr);
                    end
                end
            end
            if (s_axi_bvalid && s_axi_bready) begin
                tests_run++;
                if (exp_b.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_b: unexpected write response %b", s_axi_bresp);
                end else begin
                    eb = exp_b.pop_front();
                    if (s_axi_bresp !== eb) begin
                        tests_failed++;
                        $display("FAIL sb_b: bresp got %b want %b", s_axi_bresp, eb);
                    end
                end
            end
            if (s_axi_rvalid && s_axi_rready) begin
                tests_run++;
                if (exp_r.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_r: unexpected read response %b %h", s_axi_rresp, s_axi_rdata);
                end else begin
                    er = exp_r.pop_front();
                    if (s_axi_rresp !== er.resp || s_axi_rdata !== er.data) begin
                        tests_failed++;
                        $display("FAIL sb_r: got resp %b data %h, want resp %b data %h",
                                 s_axi_rresp, s_axi_rdata, er.resp, er.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream slave s accepts AW and W, then returns resp once bready is seen.
    task automatic slave_accept_write(input int s, input logic [RW-1:0] resp, output bit ok);
        ok = 1'b0;
        m_axi_awready[s] = 1'b1;
        m_axi_wready[s]  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_axi_bready[s]) begin
                ok = 1'b1;
                break;
            end
        end
        m_axi_awready = '0;
        m_axi_wready  = '0;
        if (ok) begin
            m_axi_bresp[s*RW +: RW] = resp;
            m_axi_bvalid[s] = 1'b1;
            tick();
            m_axi_bvalid = '0;
        end
    endtask

    task automatic master_take_b(output bit ok);
        ok = 1'b0;
        s_axi_bready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (s_axi_bvalid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) tick();
        s_axi_bready = 1'b0;
    endtask

    task automatic master_take_r(output bit ok);
        ok = 1'b0;
        s_axi_rready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (s_axi_rvalid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) tick();
        s_axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests_run++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b0 ||
            {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== '0) begin
            tests_failed++;
            $display("FAIL reset_handshakes: upstream %b downstream %b, want all 0",
                     {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid},
                     {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
        end
        tests_run++;
        if (s_axi_bresp !== '0 || s_axi_rresp !== '0 || s_axi_rdata !== '0) begin
            tests_failed++;
            $display("FAIL reset_payload: bresp %b rresp %b rdata %h, want 0",
                     s_axi_bresp, s_axi_rresp, s_axi_rdata);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL ready_before_edge: %b want 000", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
        tick();
        tests_run++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            tests_failed++;
            $display("FAIL ready_after_edge: %b want 111", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
    endtask

    task automatic test_write_same_cycle();
        bit ok;
        exp_aw.push_back('{0, 8'h04});
        exp_w.push_back('{0, 32'hDEADBEEF, 4'hF});
        exp_b.push_back(2'b00);
        s_axi_awaddr = 8'h04; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        tests_run++;
        if (m_axi_awvalid !== 2'b01 || m_axi_wvalid !== 2'b01) begin
            tests_failed++;
            $display("FAIL wr0_issue: awvalid %b wvalid %b, want 01 01", m_axi_awvalid, m_axi_wvalid);
        end
        slave_accept_write(0, 2'b00, ok);
        tests_run++;
        if (!ok || s_axi_bvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr0_bvalid: ok %0d bvalid %b, want 1 1", ok, s_axi_bvalid);
        end
        master_take_b(ok);
        tests_run++;
        if (!ok || s_axi_bvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr0_complete: ok %0d bvalid %b, want 1 0", ok, s_axi_bvalid);
        end
    endtask

    task automatic test_write_w_first();
        bit ok;
        exp_aw.push_back('{1, 8'h14});
        exp_w.push_back('{1, 32'h0BAD_F00D, 4'b0110});
        exp_b.push_back(2'b00);
        s_axi_wdata = 32'h0BAD_F00D; s_axi_wstrb = 4'b0110; s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        tick();
        tests_run++;
        if (s_axi_wready !== 1'b0 || s_axi_awready !== 1'b1 || m_axi_awvalid !== 2'b00) begin
            tests_failed++;
            $display("FAIL wfirst_wait: wready %b awready %b awvalid %b, want 0 1 00",
                     s_axi_wready, s_axi_awready, m_axi_awvalid);
        end
        s_axi_awaddr = 8'h14; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        tests_run++;
        if (m_axi_awvalid !== 2'b10 || m_axi_wvalid !== 2'b10 || s_axi_wready !== 1'b0) begin
            tests_failed++;
            $display("FAIL wfirst_issue: awvalid %b wvalid %b wready %b, want 10 10 0",
                     m_axi_awvalid, m_axi_wvalid, s_axi_wready);
        end
        slave_accept_write(1, 2'b00, ok);
        tests_run++;
        if (!ok || s_axi_bvalid !== 1'b1 || s_axi_wready !== 1'b0) begin
            tests_failed++;
            $display("FAIL wfirst_resp: ok %0d bvalid %b wready %b, want 1 1 0", ok, s_axi_bvalid, s_axi_wready);
        end
        master_take_b(ok);
        tests_run++;
        if (!ok || s_axi_wready !== 1'b1) begin
            tests_failed++;
            $display("FAIL wfirst_rearm: ok %0d wready %b, want 1 1", ok, s_axi_wready);
        end
    endtask

    task automatic test_read_decerr();
        bit ok;
        exp_r.push_back('{2'b11, 32'h0});
        s_axi_araddr = 8'h48; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        tests_run++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rresp !== 2'b11 || s_axi_rdata !== 32'h0 ||
            m_axi_arvalid !== 2'b00) begin
            tests_failed++;
            $display("FAIL rd_decerr: rvalid %b rresp %b rdata %h arvalid %b, want 1 11 0 00",
                     s_axi_rvalid, s_axi_rresp, s_axi_rdata, m_axi_arvalid);
        end
        master_take_r(ok);
        tests_run++;
        if (!ok || s_axi_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_decerr_done: ok %0d rvalid %b, want 1 0", ok, s_axi_rvalid);
        end
    endtask

    task automatic test_read_stall();
        bit ok;
        exp_ar.push_back('{1, 8'h18});
        exp_r.push_back('{2'b10, 32'h1234});
        s_axi_araddr = 8'h18; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (m_axi_arvalid !== 2'b10 || m_axi_araddr[AW +: AW] !== 8'h18) begin
                tests_failed++;
                $display("FAIL rd_stall_hold%0d: arvalid %b addr %h, want 10 18",
                         i, m_axi_arvalid, m_axi_araddr[AW +: AW]);
            end
            if (i < 4) tick();
        end
        m_axi_arready[1] = 1'b1;
        tick();
        m_axi_arready = '0;
        tests_run++;
        if (m_axi_arvalid !== 2'b00 || m_axi_rready !== 2'b10) begin
            tests_failed++;
            $display("FAIL rd_stall_wait: arvalid %b rready %b, want 00 10", m_axi_arvalid, m_axi_rready);
        end
        m_axi_rdata[DW +: DW] = 32'h1234; m_axi_rresp[RW +: RW] = 2'b10; m_axi_rvalid[1] = 1'b1;
        tick();
        m_axi_rvalid = '0;
        tests_run++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rresp !== 2'b10 || s_axi_rdata !== 32'h1234) begin
            tests_failed++;
            $display("FAIL rd_stall_resp: rvalid %b rresp %b rdata %h, want 1 10 00001234",
                     s_axi_rvalid, s_axi_rresp, s_axi_rdata);
        end
        master_take_r(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL rd_stall_timeout: no rvalid, want rvalid");
        end
    endtask

    task automatic test_concurrent();
        bit ok;
        exp_aw.push_back('{0, 8'h00});
        exp_w.push_back('{0, 32'hA5A5_0001, 4'b1001});
        exp_b.push_back(2'b10);
        exp_ar.push_back('{1, 8'h10});
        exp_r.push_back('{2'b00, 32'hCAFE_0001});
        s_axi_awaddr = 8'h00; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'hA5A5_0001; s_axi_wstrb = 4'b1001; s_axi_wvalid = 1'b1;
        s_axi_araddr = 8'h10; s_axi_arvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        tests_run++;
        if (m_axi_awvalid !== 2'b01 || m_axi_arvalid !== 2'b10) begin
            tests_failed++;
            $display("FAIL conc_issue: awvalid %b arvalid %b, want 01 10", m_axi_awvalid, m_axi_arvalid);
        end
        m_axi_awready[0] = 1'b1; m_axi_wready[0] = 1'b1; m_axi_arready[1] = 1'b1;
        tick();
        m_axi_awready = '0; m_axi_wready = '0; m_axi_arready = '0;
        m_axi_bresp[RW-1:0] = 2'b10; m_axi_bvalid[0] = 1'b1;
        m_axi_rdata[DW +: DW] = 32'hCAFE_0001; m_axi_rresp[RW +: RW] = 2'b00; m_axi_rvalid[1] = 1'b1;
        tick();
        m_axi_bvalid = '0; m_axi_rvalid = '0;
        s_axi_rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b10) begin
                tests_failed++;
                $display("FAIL conc_bhold%0d: bvalid %b bresp %b, want 1 10", i, s_axi_bvalid, s_axi_bresp);
            end
            tick();
            s_axi_rready = 1'b0;
        end
        master_take_b(ok);
        tests_run++;
        if (!ok || s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL conc_done: ok %0d bvalid %b rvalid %b, want 1 0 0", ok, s_axi_bvalid, s_axi_rvalid);
        end
    endtask

    task automatic test_reset_midtx();
        bit ok;
        exp_aw.push_back('{1, 8'h1C});
        exp_w.push_back('{1, 32'h5555_AAAA, 4'hF});
        s_axi_awaddr = 8'h1C; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h5555_AAAA; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        m_axi_awready[1] = 1'b1; m_axi_wready[1] = 1'b1;
        tick();
        m_axi_awready = '0; m_axi_wready = '0;
        tests_run++;
        if (m_axi_bready !== 2'b10) begin
            tests_failed++;
            $display("FAIL rst_pre: bready %b, want 10", m_axi_bready);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b0 ||
            {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== '0) begin
            tests_failed++;
            $display("FAIL rst_async: upstream %b downstream %b, want all 0",
                     {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid},
                     {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        exp_aw.push_back('{0, 8'h08});
        exp_w.push_back('{0, 32'h0000_7777, 4'h3});
        exp_b.push_back(2'b00);
        s_axi_awaddr = 8'h08; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h0000_7777; s_axi_wstrb = 4'h3; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        slave_accept_write(0, 2'b00, ok);
        master_take_b(ok);
        tests_run++;
        if (!ok || s_axi_awready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_recover: ok %0d awready %b, want 1 1", ok, s_axi_awready);
        end
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_write_w_first();
        test_read_decerr();
        test_read_stall();
        test_concurrent();
        test_reset_midtx();
        tick();
        tests_run++;
        if (exp_aw.size() + exp_w.size() + exp_b.size() + exp_ar.size() + exp_r.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain: leftover aw %0d w %0d b %0d ar %0d r %0d, want all 0",
                     exp_aw.size(), exp_w.size(), exp_b.size(), exp_ar.size(), exp_r.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
